// File: rtl/pc_ifid_stage.sv
// PC register, fetch request and IF/ID pipeline register of the 5-stage MIPS core.
// Resolves beq/bne/j/jal/jr/jalr in ID on forwarded operands and redirects fetch.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   ICACHE_stall/rdata/ren/addr      instruction cache fetch interface
//   DCACHE_stall                     data cache miss, freezes the whole stage
//   stall_lw, stallJ                 hazard-unit holds
//   ForwardA/B, ID_rs_data/rt_data,
//   EXMEM_ALUout, MEMWB_WriteData    ID operand sources
//   Branch, BranchNE, Jump, JumpR    decode flags of the instruction in ID
//   PC, IFID_PC4, IFID_Inst,
//   IFID_Valid                       fetch PC and IF/ID register
//   IF_Flush                         redirect taken this cycle (combinational)
//
// Optional feature macro BRANCH_STAT_EN adds the saturating counters
// stat_branch, stat_taken and stat_stall.

module pc_ifid_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ICACHE_stall,
    input  logic [31:0] ICACHE_rdata,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic        DCACHE_stall,
    input  logic        stall_lw,
    input  logic        stallJ,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic        Branch,
    input  logic        BranchNE,
    input  logic        Jump,
    input  logic        JumpR,
    input  logic [31:0] ID_rs_data,
    input  logic [31:0] ID_rt_data,
    input  logic [31:0] EXMEM_ALUout,
    input  logic [31:0] MEMWB_WriteData,
    output logic [31:0] PC,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_Inst,
    output logic        IFID_Valid,
`ifdef BRANCH_STAT_EN
    output logic [31:0] stat_branch,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_stall,
`endif
    output logic        IF_Flush
);

    typedef enum logic [1:0] {
        S_RUN,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic        freeze;
    logic        hold;
    logic        taken;
    logic        redirect;
    logic        isBranch;
    logic [31:0] rsF;
    logic [31:0] rtF;
    logic [31:0] pcPlus4;
    logic [31:0] brOffset;
    logic [31:0] target;
    logic        unusedInstBits;

    assign freeze      = ICACHE_stall | DCACHE_stall;
    assign hold        = stall_lw | stallJ;
    assign pcPlus4     = PC + 32'd4;
    assign ICACHE_addr = PC[31:2];
    assign brOffset    = {{14{IFID_Inst[15]}}, IFID_Inst[15:0], 2'b00};

    // opcode bits come pre-decoded through the flag inputs
    assign unusedInstBits = ^IFID_Inst[31:26];

    always_comb begin
        rsF = ID_rs_data;
        unique case (ForwardA)
            2'b01:   rsF = EXMEM_ALUout;
            2'b10:   rsF = MEMWB_WriteData;
            default: rsF = ID_rs_data;
        endcase
    end

    always_comb begin
        rtF = ID_rt_data;
        unique case (ForwardB)
            2'b01:   rtF = EXMEM_ALUout;
            2'b10:   rtF = MEMWB_WriteData;
            default: rtF = ID_rt_data;
        endcase
    end

    // a bubble in ID carries no real decode flags
    always_comb begin
        taken = 1'b0;
        if (IFID_Valid) begin
            taken = Jump | JumpR
                  | (Branch & (rsF == rtF))
                  | (BranchNE & (rsF != rtF));
        end
    end

    // overlapping flags are illegal; the order only keeps results repeatable
    always_comb begin
        target = IFID_PC4 + brOffset;
        if (Jump) begin
            target = {IFID_PC4[31:28], IFID_Inst[25:0], 2'b00};
        end else if (JumpR) begin
            target = rsF;
        end
    end

    // a redirect seen during a freeze is simply not taken; the same
    // IF/ID entry re-resolves once the freeze drops
    assign redirect = taken & ~freeze & ~hold;
    assign IF_Flush = redirect;
    assign isBranch = IFID_Valid & (Branch | BranchNE) & ~Jump & ~JumpR;

    always_comb begin
        stateNext = state;
        if (freeze) begin
            stateNext = state;
        end else if (hold) begin
            stateNext = S_HOLD;
        end else if (redirect) begin
            stateNext = S_FLUSH;
        end else begin
            stateNext = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_RUN;
            PC         <= RESET_PC;
            IFID_Inst  <= NOP_INST;
            IFID_PC4   <= 32'd0;
            IFID_Valid <= 1'b0;
            ICACHE_ren <= 1'b0;
        end else begin
            state      <= stateNext;
            ICACHE_ren <= 1'b1;
            if (!freeze && !hold) begin
                if (redirect) begin
                    PC         <= target;
                    IFID_Inst  <= NOP_INST;
                    IFID_PC4   <= pcPlus4;
                    IFID_Valid <= 1'b0;
                end else begin
                    PC         <= pcPlus4;
                    IFID_Inst  <= ICACHE_rdata;
                    IFID_PC4   <= pcPlus4;
                    IFID_Valid <= 1'b1;
                end
            end
        end
    end

`ifdef BRANCH_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branch <= 32'd0;
            stat_taken  <= 32'd0;
            stat_stall  <= 32'd0;
        end else if (!freeze) begin
            if (hold && stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (!hold && isBranch && stat_branch != 32'hFFFF_FFFF) begin
                stat_branch <= stat_branch + 32'd1;
            end
            if (redirect && stat_taken != 32'hFFFF_FFFF) begin
                stat_taken <= stat_taken + 32'd1;
            end
        end
    end
`else
    logic unusedStat;
    assign unusedStat = isBranch;
`endif

endmodule

// File: tb/tb_pc_ifid_stage.sv
// Scoreboard bench for pc_ifid_stage: directed redirect/stall cases
// followed by a randomised stimulus phase against a behavioural model.

module tb_pc_ifid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ICACHE_stall, DCACHE_stall, stall_lw, stallJ;
    logic [31:0] ICACHE_rdata;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [1:0]  ForwardA, ForwardB;
    logic        Branch, BranchNE, Jump, JumpR;
    logic [31:0] ID_rs_data, ID_rt_data, EXMEM_ALUout, MEMWB_WriteData;
    logic [31:0] PC, IFID_PC4, IFID_Inst;
    logic        IFID_Valid, IF_Flush;
`ifdef BRANCH_STAT_EN
    logic [31:0] stat_branch, stat_taken, stat_stall;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0020: return 32'h1000_0003;
            32'hF000_000C: return 32'h0800_0004;
            default:       return {16'h1234, a[15:0]};
        endcase
    endfunction

    assign ICACHE_rdata = imem({ICACHE_addr, 2'b00});

    pc_ifid_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ICACHE_stall(ICACHE_stall), .ICACHE_rdata(ICACHE_rdata),
        .ICACHE_ren(ICACHE_ren), .ICACHE_addr(ICACHE_addr),
        .DCACHE_stall(DCACHE_stall), .stall_lw(stall_lw), .stallJ(stallJ),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .Branch(Branch), .BranchNE(BranchNE), .Jump(Jump), .JumpR(JumpR),
        .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data),
        .EXMEM_ALUout(EXMEM_ALUout), .MEMWB_WriteData(MEMWB_WriteData),
        .PC(PC), .IFID_PC4(IFID_PC4), .IFID_Inst(IFID_Inst),
        .IFID_Valid(IFID_Valid),
`ifdef BRANCH_STAT_EN
        .stat_branch(stat_branch), .stat_taken(stat_taken),
        .stat_stall(stat_stall),
`endif
        .IF_Flush(IF_Flush)
    );

    typedef struct {
        logic [31:0] pc, pc4, inst;
        logic        valid, ren;
        logic [31:0] sb, st, ss;
    } exp_t;

    exp_t q[$];

    int vectors = 0;
    int errs = 0;

    logic [31:0] mPc, mPc4, mInst;
    logic        mValid, mRen;
    logic [31:0] mSb, mSt, mSs;
    logic        sawFlush;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic idle();
        ICACHE_stall = 0; DCACHE_stall = 0; stall_lw = 0; stallJ = 0;
        ForwardA = 0; ForwardB = 0;
        Branch = 0; BranchNE = 0; Jump = 0; JumpR = 0;
        ID_rs_data = 0; ID_rt_data = 0;
        EXMEM_ALUout = 0; MEMWB_WriteData = 0;
    endtask

    // model one clock edge from the current inputs, push, clock, pop, compare
    task automatic step();
        logic        fz, hd, tk, fl;
        logic [31:0] a, b, tgt;
        exp_t        e, g;
        #1;
        fz = ICACHE_stall || DCACHE_stall;
        hd = stall_lw || stallJ;
        a = (ForwardA == 2'b01) ? EXMEM_ALUout :
            (ForwardA == 2'b10) ? MEMWB_WriteData : ID_rs_data;
        b = (ForwardB == 2'b01) ? EXMEM_ALUout :
            (ForwardB == 2'b10) ? MEMWB_WriteData : ID_rt_data;
        tk = mValid && (Jump || JumpR ||
                        (Branch && a == b) || (BranchNE && a != b));
        if (Jump)       tgt = {mPc4[31:28], mInst[25:0], 2'b00};
        else if (JumpR) tgt = a;
        else            tgt = mPc4 + {{14{mInst[15]}}, mInst[15:0], 2'b00};
        fl = tk && !fz && !hd;
        sawFlush = IF_Flush;
        if (rst_n) check("flush", {31'd0, IF_Flush}, {31'd0, fl});
        if (!rst_n) begin
            mPc = 32'd0; mPc4 = 32'd0; mInst = 32'd0;
            mValid = 0; mRen = 0; mSb = 0; mSt = 0; mSs = 0;
        end else begin
            mRen = 1;
            if (!fz) begin
                if (hd) mSs = sat(mSs);
                if (!hd && mValid && (Branch || BranchNE) && !Jump && !JumpR)
                    mSb = sat(mSb);
                if (fl) mSt = sat(mSt);
                if (!hd) begin
                    mPc4 = mPc + 32'd4;
                    if (fl) begin
                        mInst = 32'd0; mValid = 0; mPc = tgt;
                    end else begin
                        mInst = imem(mPc); mValid = 1; mPc = mPc + 32'd4;
                    end
                end
            end
        end
        e.pc = mPc; e.pc4 = mPc4; e.inst = mInst; e.valid = mValid;
        e.ren = mRen; e.sb = mSb; e.st = mSt; e.ss = mSs;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        check("pc", PC, g.pc);
        check("addr", {2'b00, ICACHE_addr}, {2'b00, g.pc[31:2]});
        check("pc4", IFID_PC4, g.pc4);
        check("inst", IFID_Inst, g.inst);
        check("valid", {31'd0, IFID_Valid}, {31'd0, g.valid});
        check("ren", {31'd0, ICACHE_ren}, {31'd0, g.ren});
`ifdef BRANCH_STAT_EN
        check("stat_branch", stat_branch, g.sb);
        check("stat_taken", stat_taken, g.st);
        check("stat_stall", stat_stall, g.ss);
`endif
    endtask

    initial begin
        idle();
        rst_n = 0;
        mPc = 0; mPc4 = 0; mInst = 0; mValid = 0; mRen = 0;
        mSb = 0; mSt = 0; mSs = 0;
        @(negedge clk);
        step(); step();
        check("rst_pc", PC, 32'h0);
        check("rst_valid", {31'd0, IFID_Valid}, 32'd0);
        check("rst_ren", {31'd0, ICACHE_ren}, 32'd0);
        rst_n = 1;

        for (int i = 0; i < 4; i++) step();
        check("seq_pc", PC, 32'h10);
        check("seq_pc4", IFID_PC4, 32'h10);
        for (int i = 0; i < 5; i++) step();
        check("beq_id", IFID_Inst, 32'h1000_0003);

        Branch = 1; ForwardA = 2'b01; ForwardB = 2'b10;
        EXMEM_ALUout = 5; MEMWB_WriteData = 5;
        ID_rs_data = 9; ID_rt_data = 7;
        step();
        check("beq_flush", {31'd0, sawFlush}, 32'd1);
        check("beq_pc", PC, 32'h30);
        check("beq_bubble", {31'd0, IFID_Valid}, 32'd0);

        idle(); Jump = 1;
        step();
        check("bubble_ignored", PC, 32'h34);

        idle(); JumpR = 1; stallJ = 1; ID_rs_data = 32'h400;
        step(); step();
        check("jr_hold", PC, 32'h34);
        stallJ = 0;
        step();
        check("jr_pc", PC, 32'h400);

        idle(); step();
        BranchNE = 1; ID_rs_data = 1; ID_rt_data = 2; ICACHE_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("miss_addr", {2'b00, ICACHE_addr}, 32'h101);
        end
        ICACHE_stall = 0;
        step();
        check("bne_pc", PC, 32'h1404);

        idle(); step();
        JumpR = 1; ForwardA = 2'b11; ID_rs_data = 32'hF000_000C;
        EXMEM_ALUout = 32'h1111_1110;
        step();
        check("jr_fwd11", PC, 32'hF000_000C);
        idle(); step();
        Jump = 1;
        step();
        check("j_pc", PC, 32'hF000_0010);

        idle(); step();
        JumpR = 1; ID_rs_data = 32'hFFFF_FFF8;
        step();
        idle(); step();
        check("pre_wrap", PC, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", PC, 32'h0);
        check("wrap_pc4", IFID_PC4, 32'h0);

        Jump = 1; JumpR = 1; Branch = 1; ID_rs_data = 32'h44;
        step();
        check("multi_pc", PC, 32'h08D3_FFF0);

        idle();
        for (int i = 0; i < 300; i++) begin
            ICACHE_stall = ($urandom_range(0, 99) < 15);
            DCACHE_stall = ($urandom_range(0, 99) < 10);
            stall_lw     = ($urandom_range(0, 99) < 10);
            stallJ       = ($urandom_range(0, 99) < 10);
            Branch       = ($urandom_range(0, 99) < 15);
            BranchNE     = ($urandom_range(0, 99) < 15);
            Jump         = ($urandom_range(0, 99) < 8);
            JumpR        = ($urandom_range(0, 99) < 8);
            ForwardA     = 2'($urandom_range(0, 3));
            ForwardB     = 2'($urandom_range(0, 3));
            ID_rs_data   = 32'($urandom_range(0, 3)) << 4;
            ID_rt_data   = 32'($urandom_range(0, 3)) << 4;
            EXMEM_ALUout = 32'($urandom_range(0, 3)) << 4;
            MEMWB_WriteData = 32'($urandom_range(0, 3)) << 4;
            step();
        end

        idle(); ICACHE_stall = 1; rst_n = 0;
        step();
        check("rst_miss_pc", PC, 32'h0);
        check("rst_miss_ren", {31'd0, ICACHE_ren}, 32'd0);
        idle(); rst_n = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
